// File: rtl/i_cache_pkg.sv
// Shared i_cache geometry, address-field layout and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i_cache_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 8;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = WORD_SIZE - IDX_W - OFF_W;
    localparam int LINE_W     = LINE_WORDS * WORD_SIZE;
    localparam int CNT_W      = 16;

    typedef enum logic {
        ICS_IDLE = 1'b0,
        ICS_MISS = 1'b1
    } ics_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } line_addr_t;

    function automatic logic [WORD_SIZE-1:0] line_base(input line_addr_t la);
        return {la, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/i_cache.sv
// Direct-mapped read-only blocking instruction cache with hit/miss counters.
// Latency: hit served combinationally; miss costs a fill (>= 2 cycles) then serves next cycle.
// Backpressure: i_ready low while the fetch misses; mem_read held until mem_valid pulse.
module i_cache
    import i_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_mem_read,
    input  logic [WORD_SIZE-1:0] i_address,
    input  logic                 invalidate,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [LINE_W-1:0]    mem_rdata,
    input  logic                 mem_valid,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    ics_state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];
    line_addr_t           fill_addr_q;

    addr_t req;
    logic  hit;
    logic  miss_start;
    logic  fill_done;

    assign req = addr_t'(i_address);
    assign hit = valid_q[req.idx] && (tag_q[req.idx] == req.tag);

    // Hits are served in either state, so a redirect during a fill can still hit other lines.
    assign i_ready = i_mem_read && hit;
    assign i_data  = i_ready ? data_q[req.idx][req.off] : '0;

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_address = '0;
        miss_start  = 1'b0;
        fill_done   = 1'b0;
        case (state_q)
            ICS_IDLE: begin
                if (i_mem_read && !hit) begin
                    miss_start = 1'b1;
                    state_d    = ICS_MISS;
                end
            end
            ICS_MISS: begin
                mem_read    = 1'b1;
                mem_address = line_base(fill_addr_q);
                if (mem_valid) begin
                    fill_done = 1'b1;
                    state_d   = ICS_IDLE;
                end
            end
            default: state_d = ICS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ICS_IDLE;
            valid_q     <= '0;
            fill_addr_q <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                fill_addr_q <= {req.tag, req.idx};
                miss_count  <= miss_count + CNT_W'(1);
            end
            if (i_ready) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            // Invalidate wins over a fill landing on the same edge.
            if (invalidate) begin
                valid_q <= '0;
            end else if (fill_done) begin
                valid_q[fill_addr_q.idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && fill_done) begin
            tag_q[fill_addr_q.idx] <= fill_addr_q.tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[fill_addr_q.idx][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule
